// File: rtl/resonator_ddc_axis_stall_detector.sv
// Per-channel AXI4-Stream stall detector: counts consecutive stall cycles on the
// input (starved) and output (backpressured) streams and flags persistent blocks.
module resonator_ddc_axis_stall_detector #(
    parameter int THRESH = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             s_tvalid,
    input  logic             s_tready,
    input  logic             m_tvalid,
    input  logic             m_tready,
    input  logic             clear,
    output logic [1:0]       axis_block_sigs,
    output logic [1:0]       sticky_block,
    output logic             first_valid,
    output logic             first_ch,
    output logic [CNT_W-1:0] max_stall0,
    output logic [CNT_W-1:0] max_stall1
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] max_of(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [CNT_W-1:0] max_q   [2];
    logic [CNT_W-1:0] max_d   [2];
    logic [1:0]       sticky_q;
    logic [1:0]       sticky_d;
    logic             first_valid_q;
    logic             first_valid_d;
    logic             first_ch_q;
    logic             first_ch_d;
    logic [1:0]       stall;
    logic [1:0]       enter;

    assign stall[0] = s_tready & ~s_tvalid;
    assign stall[1] = m_tvalid & ~m_tready;

    // Per-channel run-length state machine; any non-stall cycle restarts the run.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            if (stall[i]) begin
                case (state_q[i])
                    ST_IDLE: begin
                        cnt_d[i]   = CNT_W'(1);
                        state_d[i] = (THRESH == 1) ? ST_BLOCKED : ST_COUNT;
                    end
                    ST_COUNT: begin
                        cnt_d[i]   = sat_inc(cnt_q[i]);
                        state_d[i] = (cnt_d[i] == THRESH_C) ? ST_BLOCKED : ST_COUNT;
                    end
                    ST_BLOCKED: begin
                        cnt_d[i]   = sat_inc(cnt_q[i]);
                        state_d[i] = ST_BLOCKED;
                    end
                    default: begin
                        cnt_d[i]   = '0;
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end
            enter[i] = (state_d[i] == ST_BLOCKED) && (state_q[i] != ST_BLOCKED);
        end
    end

    // Software-visible status; a block entering on a clear edge survives the clear.
    always_comb begin
        sticky_d      = (clear ? 2'b00 : sticky_q) | enter;
        first_valid_d = first_valid_q & ~clear;
        first_ch_d    = clear ? 1'b0 : first_ch_q;
        if (!first_valid_d && (enter != 2'b00)) begin
            first_valid_d = 1'b1;
            first_ch_d    = ~enter[0];
        end
        for (int i = 0; i < 2; i++) begin
            max_d[i] = clear ? cnt_d[i] : max_of(max_q[i], cnt_d[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                max_q[i]   <= '0;
            end
            sticky_q      <= 2'b00;
            first_valid_q <= 1'b0;
            first_ch_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                max_q[i]   <= max_d[i];
            end
            sticky_q      <= sticky_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
        end
    end

    assign axis_block_sigs[0] = (state_q[0] == ST_BLOCKED);
    assign axis_block_sigs[1] = (state_q[1] == ST_BLOCKED);
    assign sticky_block       = sticky_q;
    assign first_valid        = first_valid_q;
    assign first_ch           = first_ch_q;
    assign max_stall0         = max_q[0];
    assign max_stall1         = max_q[1];

endmodule

// File: tb/tb_resonator_ddc_axis_stall_detector.sv
// Bench for resonator_ddc_axis_stall_detector: three parameterisations driven in
// lockstep and compared against a run-length reference model.
module tb_resonator_ddc_axis_stall_detector;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic s_tvalid = 1'b0, s_tready = 1'b0, m_tvalid = 1'b0, m_tready = 1'b0, clear = 1'b0;

    always #5 clock = ~clock;

    // Instance a: THRESH=4, CNT_W=16; b: THRESH=4, CNT_W=4; c: THRESH=1, CNT_W=4
    logic [1:0]  a_blk, a_stk, b_blk, b_stk, c_blk, c_stk;
    logic        a_fv, a_fch, b_fv, b_fch, c_fv, c_fch;
    logic [15:0] a_mx0, a_mx1;
    logic [3:0]  b_mx0, b_mx1, c_mx0, c_mx1;

    resonator_ddc_axis_stall_detector #(.THRESH(4), .CNT_W(16)) dut_a (
        .clock(clock), .reset_n(reset_n), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .clear(clear),
        .axis_block_sigs(a_blk), .sticky_block(a_stk), .first_valid(a_fv),
        .first_ch(a_fch), .max_stall0(a_mx0), .max_stall1(a_mx1));

    resonator_ddc_axis_stall_detector #(.THRESH(4), .CNT_W(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .clear(clear),
        .axis_block_sigs(b_blk), .sticky_block(b_stk), .first_valid(b_fv),
        .first_ch(b_fch), .max_stall0(b_mx0), .max_stall1(b_mx1));

    resonator_ddc_axis_stall_detector #(.THRESH(1), .CNT_W(4)) dut_c (
        .clock(clock), .reset_n(reset_n), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .clear(clear),
        .axis_block_sigs(c_blk), .sticky_block(c_stk), .first_valid(c_fv),
        .first_ch(c_fch), .max_stall0(c_mx0), .max_stall1(c_mx1));

    // Reference model: a block is simply "current stall run >= THRESH"
    int       th_m [3] = '{4, 4, 1};
    int       cm_m [3] = '{65535, 15, 15};
    int       run_m [3][2];
    int       mx_m  [3][2];
    bit [1:0] stk_m [3];
    bit       fv_m  [3];
    bit       fch_m [3];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            run_m[k][0] = 0; run_m[k][1] = 0;
            mx_m[k][0]  = 0; mx_m[k][1]  = 0;
            stk_m[k] = 2'b00; fv_m[k] = 1'b0; fch_m[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit st0, input bit st1, input bit clr);
        for (int k = 0; k < 3; k++) begin
            bit [1:0] en;
            int       cv [2];
            en = 2'b00;
            for (int c = 0; c < 2; c++) begin
                bit st;
                bit prev;
                st   = (c == 0) ? st0 : st1;
                prev = (run_m[k][c] >= th_m[k]);
                run_m[k][c] = st ? run_m[k][c] + 1 : 0;
                en[c] = (run_m[k][c] >= th_m[k]) && !prev;
                cv[c] = (run_m[k][c] > cm_m[k]) ? cm_m[k] : run_m[k][c];
            end
            if (clr) begin
                stk_m[k] = 2'b00; fv_m[k] = 1'b0; fch_m[k] = 1'b0;
            end
            stk_m[k] = stk_m[k] | en;
            if (!fv_m[k] && en != 2'b00) begin
                fv_m[k]  = 1'b1;
                fch_m[k] = en[0] ? 1'b0 : 1'b1;
            end
            for (int c = 0; c < 2; c++)
                mx_m[k][c] = clr ? cv[c] : ((cv[c] > mx_m[k][c]) ? cv[c] : mx_m[k][c]);
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[inst %0d] observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    task automatic chk_inst(input int k, input logic [1:0] blk, input logic [1:0] stk,
                            input logic fv, input logic fch, input logic [15:0] mx0,
                            input logic [15:0] mx1);
        logic [1:0] eb;
        eb = {run_m[k][1] >= th_m[k], run_m[k][0] >= th_m[k]};
        chk("axis_block_sigs", k, 32'(blk), 32'(eb));
        chk("sticky_block",    k, 32'(stk), 32'(stk_m[k]));
        chk("first_valid",     k, 32'(fv),  32'(fv_m[k]));
        chk("first_ch",        k, 32'(fch), 32'(fch_m[k]));
        chk("max_stall0",      k, 32'(mx0), 32'(mx_m[k][0]));
        chk("max_stall1",      k, 32'(mx1), 32'(mx_m[k][1]));
    endtask

    task automatic check_all();
        chk_inst(0, a_blk, a_stk, a_fv, a_fch, a_mx0, a_mx1);
        chk_inst(1, b_blk, b_stk, b_fv, b_fch, {12'b0, b_mx0}, {12'b0, b_mx1});
        chk_inst(2, c_blk, c_stk, c_fv, c_fch, {12'b0, c_mx0}, {12'b0, c_mx1});
    endtask

    task automatic step(input logic sv, input logic sr, input logic mv, input logic mr,
                        input logic clr);
        s_tvalid = sv; s_tready = sr; m_tvalid = mv; m_tready = mr; clear = clr;
        @(posedge clock);
        model_edge(sr & ~sv, mv & ~mr, clr);
        #1;
        check_all();
    endtask

    // Pulls reset low between edges, checks outputs before and after an edge, releases.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("async_reset_blk_a", 0, 32'(a_blk), 32'd0);
        chk("async_reset_mx0_a", 0, 32'(a_mx0), 32'd0);
        @(posedge clock);
        #1 check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin : stim
        int hi;
        model_reset();
        #3 check_all();
        chk("reset_first_valid_a", 0, 32'(a_fv), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Short starvation run ended by a handshake never blocks at THRESH=4
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp1_blk", 0, 32'(a_blk), 32'd0);
        chk("tp1_max0", 0, 32'(a_mx0), 32'd3);
        chk("tp1_sticky", 0, 32'(a_stk), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure for 6 cycles: bit1 high for 3 of them
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (a_blk[1]) hi++;
        end
        chk("tp2_hi_cycles", 0, 32'(hi), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("tp2_drop", 0, 32'(a_blk), 32'd0);
        chk("tp2_sticky", 0, 32'(a_stk), 32'b10);
        chk("tp2_first_ch", 0, 32'(a_fch), 32'd1);
        chk("tp2_max1", 0, 32'(a_mx1), 32'd6);

        // Simultaneous block on both channels: channel 0 wins the first capture
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 3) chk("tp3_both_rise", 0, 32'(a_blk), 32'b11);
        end
        chk("tp3_first_ch", 0, 32'(a_fch), 32'd0);
        chk("tp3_sticky", 0, 32'(a_stk), 32'b11);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Long starvation saturates the narrow counter
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp4_sat_max0_b", 1, 32'(b_mx0), 32'd15);
        chk("tp4_blk_b", 1, 32'(b_blk), 32'b01);
        chk("tp4_max0_a", 0, 32'(a_mx0), 32'd20);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp4_drop_b", 1, 32'(b_blk), 32'd0);

        // Clear mid-stall, then clear while blocked
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp5_blk", 0, 32'(a_blk), 32'b01);
        chk("tp5_sticky", 0, 32'(a_stk), 32'b01);
        chk("tp5_max0", 0, 32'(a_mx0), 32'd4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tp5_clr_sticky", 0, 32'(a_stk), 32'd0);
        chk("tp5_clr_max0", 0, 32'(a_mx0), 32'd5);
        chk("tp5_clr_blk", 0, 32'(a_blk), 32'b01);

        // Reset while blocked, then a fresh run needs THRESH cycles again
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 2) chk("tp6_not_yet", 0, 32'(a_blk), 32'd0);
        end
        chk("tp6_reassert", 0, 32'(a_blk), 32'b01);

        // Randomized traffic with occasional clears and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            logic sv, sr, mv, mr, cl;
            sv = ($urandom_range(0, 99) < 25);
            sr = ($urandom_range(0, 99) < 85);
            mv = ($urandom_range(0, 99) < 85);
            mr = ($urandom_range(0, 99) < 25);
            cl = ($urandom_range(0, 99) < 5);
            step(sv, sr, mv, mr, cl);
            if (i == 200) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
